// File: rtl/alu_result_tx_pkg.sv
// Shared types and constants for the ALU result UART transmitter.
// States, oversampling factor and baud divisor helper.
package alu_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam int OVERSAMPLE = 16;

  // Clock cycles per oversampling tick, rounded to nearest.
  function automatic int calc_baud_m(input longint clk_freq, input longint baud_rate);
    return int'((clk_freq + 8 * baud_rate) / (16 * baud_rate));
  endfunction

endpackage

// File: rtl/alu_result_tx_if.sv
// Request channel into the transmitter: ALU result plus valid/ready handshake.
// A transfer happens on a rising clock edge where i_valid and o_ready are both high.
interface alu_result_tx_if #(
  parameter int NB_DATA = 8
);
  logic [NB_DATA-1:0] i_data;
  logic               i_valid;
  logic               o_ready;

  modport master (output i_data, output i_valid, input o_ready);
  modport slave  (input i_data, input i_valid, output o_ready);
endinterface

// File: rtl/alu_result_tx_baud_rate_gen.sv
// Oversampling tick generator: one-cycle tick every M clocks while enabled,
// counter held at zero while disabled so frames start phase-aligned.
module baud_rate_gen #(
  parameter int M = 163
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_enable,
  output logic o_tick
);

  localparam int CW = (M > 1) ? $clog2(M) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CW'(M - 1));

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt <= '0;
    end else if (!i_enable || w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = i_enable && w_wrap;

endmodule

// File: rtl/alu_result_tx.sv
// UART 8N1-style transmitter for the ALU result. Optional even parity bit is
// enabled by defining ALU_RESULT_TX_PARITY_EN.
module alu_result_tx
  import alu_tx_pkg::*;
#(
  parameter int NB_DATA   = 8,
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 19_200,
  parameter int SB_TICKS  = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  alu_result_tx_if.slave   s_if,
  output logic             o_tx,
  output logic             o_done,
  output state_t           o_dbg_state
);

  localparam int M      = calc_baud_m(CLK_FREQ, BAUD_RATE);
  localparam int TMAX   = (SB_TICKS > OVERSAMPLE) ? SB_TICKS : OVERSAMPLE;
  localparam int TW     = $clog2(TMAX);
  localparam int BW     = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  state_t               r_state, w_state_next;
  logic [TW-1:0]        r_tick_cnt, w_tick_cnt_next;
  logic [BW-1:0]        r_bit_cnt, w_bit_cnt_next;
  logic [NB_DATA-1:0]   r_shift, w_shift_next;
  logic                 r_tx, w_tx_next;
  logic                 r_done, w_done_next;
  logic                 w_tick;
`ifdef ALU_RESULT_TX_PARITY_EN
  logic                 r_parity, w_parity_next;
`endif

  baud_rate_gen #(.M(M)) u_baud (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_enable (r_state != ST_IDLE),
    .o_tick   (w_tick)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= ST_IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_tick_cnt <= w_tick_cnt_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_shift    <= w_shift_next;
      r_tx       <= w_tx_next;
      r_done     <= w_done_next;
    end
  end

`ifdef ALU_RESULT_TX_PARITY_EN
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_parity <= 1'b0;
    end else begin
      r_parity <= w_parity_next;
    end
  end
`endif

  // The line value registered here is the one the current state calls for, so
  // o_tx trails the state by one cycle and every symbol keeps its full length.
  always_comb begin
    w_state_next    = r_state;
    w_tick_cnt_next = r_tick_cnt;
    w_bit_cnt_next  = r_bit_cnt;
    w_shift_next    = r_shift;
    w_tx_next       = 1'b1;
    w_done_next     = 1'b0;
`ifdef ALU_RESULT_TX_PARITY_EN
    w_parity_next   = r_parity;
`endif
    case (r_state)
      ST_IDLE: begin
        if (s_if.i_valid) begin
          w_shift_next    = s_if.i_data;
          w_tick_cnt_next = '0;
          w_bit_cnt_next  = '0;
          w_state_next    = ST_START;
`ifdef ALU_RESULT_TX_PARITY_EN
          w_parity_next   = ^s_if.i_data;
`endif
        end
      end
      ST_START: begin
        w_tx_next = 1'b0;
        if (w_tick) begin
          if (r_tick_cnt == TW'(OVERSAMPLE - 1)) begin
            w_tick_cnt_next = '0;
            w_bit_cnt_next  = '0;
            w_state_next    = ST_DATA;
          end else begin
            w_tick_cnt_next = r_tick_cnt + 1'b1;
          end
        end
      end
      ST_DATA: begin
        w_tx_next = r_shift[0];
        if (w_tick) begin
          if (r_tick_cnt == TW'(OVERSAMPLE - 1)) begin
            w_tick_cnt_next = '0;
            w_shift_next    = r_shift >> 1;
            if (r_bit_cnt == BW'(NB_DATA - 1)) begin
`ifdef ALU_RESULT_TX_PARITY_EN
              w_state_next = ST_PARITY;
`else
              w_state_next = ST_STOP;
`endif
            end else begin
              w_bit_cnt_next = r_bit_cnt + 1'b1;
            end
          end else begin
            w_tick_cnt_next = r_tick_cnt + 1'b1;
          end
        end
      end
`ifdef ALU_RESULT_TX_PARITY_EN
      ST_PARITY: begin
        w_tx_next = r_parity;
        if (w_tick) begin
          if (r_tick_cnt == TW'(OVERSAMPLE - 1)) begin
            w_tick_cnt_next = '0;
            w_state_next    = ST_STOP;
          end else begin
            w_tick_cnt_next = r_tick_cnt + 1'b1;
          end
        end
      end
`endif
      ST_STOP: begin
        w_tx_next = 1'b1;
        if (w_tick) begin
          if (r_tick_cnt == TW'(SB_TICKS - 1)) begin
            w_tick_cnt_next = '0;
            w_done_next     = 1'b1;
            w_state_next    = ST_IDLE;
          end else begin
            w_tick_cnt_next = r_tick_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign s_if.o_ready = (r_state == ST_IDLE);
  assign o_tx         = r_tx;
  assign o_done       = r_done;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_alu_result_tx.sv
// Bench for alu_result_tx: directed scenarios plus random requests, every cycle
// compared against a frame-timing reference model built from line-level rules.
module tb_alu_result_tx;
  import alu_tx_pkg::*;

  localparam int M_TB  = 10;
  localparam int BIT_C = 16 * M_TB;
`ifdef ALU_RESULT_TX_PARITY_EN
  localparam int P_TB  = 1;
`else
  localparam int P_TB  = 0;
`endif
  localparam int FRAME_LEN = (16 * (1 + 8 + P_TB) + 16) * M_TB;
  localparam int NONE      = -1000000;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   o_tx, o_done;
  state_t dbg_state;

  alu_result_tx_if #(.NB_DATA(8)) bus ();

  alu_result_tx #(
    .NB_DATA   (8),
    .CLK_FREQ  (1_600_000),
    .BAUD_RATE (10_000),
    .SB_TICKS  (16)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst_n),
    .s_if        (bus.slave),
    .o_tx        (o_tx),
    .o_done      (o_done),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // exp_q holds the result currently on the line; acc_edge is its acceptance edge.
  logic [7:0] exp_q[$];
  int   acc_edge  = NONE;
  logic exp_tx    = 1'b1;
  logic exp_ready = 1'b1;
  logic exp_done  = 1'b0;

  function automatic logic line_bit(input int s, input logic [7:0] d);
    int b;
    b = s / BIT_C;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (P_TB == 1 && b == 9) return ^d;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_edge  = NONE;
      exp_q.delete();
      exp_tx    = 1'b1;
      exp_ready = 1'b1;
      exp_done  = 1'b0;
    end else begin
      int s;
      cyc++;
      if (exp_ready && bus.i_valid) begin
        acc_edge = cyc;
        exp_q.push_back(bus.i_data);
      end
      s         = cyc - 1 - acc_edge;
      exp_ready = (cyc >= acc_edge + FRAME_LEN);
      exp_done  = (cyc == acc_edge + FRAME_LEN);
      exp_tx    = (s >= 0 && s < FRAME_LEN && exp_q.size() > 0) ? line_bit(s, exp_q[0]) : 1'b1;
      if (exp_done) void'(exp_q.pop_front());
    end
  end

  always @(negedge clk) begin
    check("o_tx", {31'd0, o_tx}, {31'd0, exp_tx});
    check("o_ready", {31'd0, bus.o_ready}, {31'd0, exp_ready});
    check("o_done", {31'd0, o_done}, {31'd0, exp_done});
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input int hold);
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_data  = d;
    wait_cycles(hold);
    bus.i_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    rst_n       = 1'b0;
    wait_cycles(5);
    rst_n = 1'b1;
    #1;
    check("reset_tx", {31'd0, o_tx}, 32'd1);
    check("reset_ready", {31'd0, bus.o_ready}, 32'd1);
    check("reset_done", {31'd0, o_done}, 32'd0);
    wait_cycles(2000);

    // Single frame.
    send(8'hA5, 1);
    wait_cycles(FRAME_LEN + 100);

    // Request while busy must be dropped.
    send(8'h3C, 1);
    wait_cycles(499);
    send(8'hFF, 1);
    wait_cycles(FRAME_LEN + 100);

    // Back-to-back with valid held high.
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_data  = 8'h01;
    @(negedge clk);
    bus.i_data  = 8'h80;
    wait_cycles(FRAME_LEN + 100);
    bus.i_valid = 1'b0;
    wait_cycles(FRAME_LEN + 100);

    // Reset in the middle of a frame.
    send(8'h55, 1);
    wait_cycles(698);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_tx", {31'd0, o_tx}, 32'd1);
    check("async_reset_ready", {31'd0, bus.o_ready}, 32'd1);
    wait_cycles(3);
    rst_n = 1'b1;
    send(8'h0F, 1);
    wait_cycles(FRAME_LEN + 100);

    // Parity-oriented patterns (plain frames in the default build).
    send(8'h07, 1);
    wait_cycles(FRAME_LEN + 20);
    send(8'h03, 1);
    wait_cycles(FRAME_LEN + 20);

    // Random requests, gaps and hold lengths.
    for (int i = 0; i < 8; i++) begin
      send(8'($urandom), $urandom_range(1, 3));
      wait_cycles($urandom_range(FRAME_LEN - 300, FRAME_LEN + 300));
    end
    wait_cycles(FRAME_LEN + 100);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_result_tx.md
# alu_result_tx

Serial transmitter for the ALU result path: it captures an NB_DATA-bit ALU result on a valid/ready handshake and sends it as an 8N1-style UART frame on a single output line. Operands and opcode enter the ALU through the existing operand-loading block. This block is the outgoing side that returns the result to the host PC, replacing the LED readout.

## Interface
- NB_DATA, 8, data bits per frame (ALU result width)
- CLK_FREQ, 50_000_000, system clock frequency in Hz
- BAUD_RATE, 19_200, line rate in bit/s
- SB_TICKS, 16, oversampling ticks in the stop bit (16 = 1 stop bit, 32 = 2)

Ports:
- i_clk  in  1  system clock, rising edge
- i_reset  in  1  reset, asynchronous, active-low
- i_data  in  NB_DATA  ALU result to send
- i_valid  in  1  request; accepted in a cycle where o_ready=1
- o_ready  out  1  high when idle and able to accept a request
- o_tx  out  1  serial line, idles high
- o_done  out  1  one-cycle pulse when a frame completes

## Operation
- Tick generator: M = CLK_FREQ/(16*BAUD_RATE), rounded to nearest; counter 0..M-1; tick when counter==M-1.
- Tick counter is held at 0 in IDLE and runs in all other states, so every frame has the same cycle-exact length.
- States:
  - IDLE: o_tx=1, o_ready=1. If i_valid, load the shift register with i_data and go to START.
  - START: o_tx=0 for 16 ticks, then go to DATA.
  - DATA: send bits LSB first, 16 ticks each. After bit NB_DATA-1, go to PARITY (if the feature is enabled) or STOP.
  - STOP: o_tx=1 for SB_TICKS ticks, then go to IDLE and pulse o_done.
- o_ready is combinational: (state==IDLE).
- o_tx and o_done are registered.
- i_valid while busy is ignored. There is no queue, and the request is not remembered.
- i_data is sampled only at acceptance; later changes do not affect the frame in progress.
- Back-to-back frames: i_valid may be accepted in the same cycle o_done is high (the first IDLE cycle).
- Reset, including mid-frame: state=IDLE, o_tx=1, o_done=0, counters=0, shift register=0. The partial frame is abandoned.

## Timing
- Reset values: o_tx=1, o_ready=1, o_done=0.
- Acceptance edge k: o_tx=0 from edge k+1.
- Start bit lasts 16*M cycles; each data bit lasts 16*M cycles; stop bit lasts SB_TICKS*M cycles.
- Frame duration from edge k+1 to the return to IDLE: (16*(1+NB_DATA+P) + SB_TICKS)*M cycles, where P=1 with parity and 0 without.
- o_done is high for exactly one cycle, coincident with the first IDLE cycle.

## Configuration
- Macro: ALU_RESULT_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It drives the even-parity bit (XOR of all NB_DATA data bits) for 16 ticks, so P=1.
- Undefined: DATA goes directly to STOP, and no parity logic is synthesized (P=0).

## Structure
- Shared header/package alu_tx_pkg:
  - state encodings IDLE/START/DATA/PARITY/STOP
  - oversampling constant 16
  - function computing M from CLK_FREQ and BAUD_RATE
- One sub-module: baud_rate_gen (parameter M; inputs i_clk, i_reset, i_enable; output o_tick).
- The top FSM instantiates baud_rate_gen and drives its i_enable from state!=IDLE.

## Test plan
Bench parameters: CLK_FREQ=1_600_000, BAUD_RATE=10_000 (M=10), SB_TICKS=16.
- Reset: hold i_reset=0 for 5 cycles, then release -> o_tx=1, o_ready=1, o_done=0, and no activity for 2000 cycles.
- Single frame, no parity: i_data=8'hA5, i_valid for 1 cycle -> o_tx low 160 cycles, then bits 1,0,1,0,0,1,0,1 at 160 cycles each, then high 160 cycles. o_done pulses at 1600 cycles after the acceptance edge.
- Busy ignore: during the frame for 8'h3C, assert i_valid with 8'hFF at cycle 500 -> the line carries 8'h3C only, with no second frame and one o_done pulse.
- Back-to-back: hold i_valid=1 with 8'h01 and then 8'h80 -> the second start bit begins exactly 1 cycle after the o_done pulse, and there are 2 frames with no idle gap beyond that cycle.
- Mid-frame reset: assert i_reset=0 at cycle 700 of frame 8'h55 -> o_tx=1 asynchronously and o_ready=1 after release. A new frame with 8'h0F then transmits correctly.
- With ALU_RESULT_TX_PARITY_EN: i_data=8'h07 -> parity bit=1 after data, and frame length is 1760 cycles. With 8'h03 -> parity bit=0.
